// File: rtl/astro_colisao_pkg.sv
// Shared definitions for the shot/asteroid collision sweeper:
// 4-bit state codes and a width helper that never returns zero.
package astro_colisao_pkg;

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    INICIO      = 4'd1,
    LE_TIRO     = 4'd2,
    AVALIA_TIRO = 4'd3,
    LE_ASTE     = 4'd4,
    COMPARA     = 4'd5,
    APAGA       = 4'd6,
    PROX_TIRO   = 4'd7,
    FIM         = 4'd8
  } estado_t;

  // Address width for n slots; a single slot still needs one address bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/contador_m_rco.sv
// Modulo-M up counter with synchronous clear, count enable and
// ripple-carry-out flag raised while the count sits at M-1.
module contador_m_rco #(
  parameter int M = 4,
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         limpa,
  input  logic         conta,
  output logic [W-1:0] valor,
  output logic         rco
);

  assign rco = (valor == W'(M - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valor <= '0;
    end else if (limpa) begin
      valor <= '0;
    end else if (conta) begin
      valor <= rco ? '0 : valor + 1'b1;
    end
  end

endmodule

// File: rtl/compara_colisoes_param.sv
// Per-frame collision sweep: walks every shot against every asteroid through
// the memory address ports and issues clear strobes for each detected hit.
module compara_colisoes_param
  import astro_colisao_pkg::*;
#(
  parameter  int N_TIROS      = 4,
  parameter  int N_ASTEROIDES = 8,
  parameter  int LARG_COORD   = 4,
  parameter  int TOLERANCIA   = 0,
  parameter  int LARG_PONTOS  = 8,
  localparam int LT           = clog2_min1(N_TIROS),
  localparam int LA           = clog2_min1(N_ASTEROIDES)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   inicia,
  input  logic                   modo_perfurante,
  input  logic [LARG_COORD-1:0]  tiro_x,
  input  logic [LARG_COORD-1:0]  tiro_y,
  input  logic                   tiro_ativo,
  input  logic [LARG_COORD-1:0]  aste_x,
  input  logic [LARG_COORD-1:0]  aste_y,
  input  logic                   aste_ativo,
  output logic [LT-1:0]          tiro_addr,
  output logic [LA-1:0]          aste_addr,
  output logic                   apaga_tiro,
  output logic                   apaga_asteroide,
  output logic [LARG_PONTOS-1:0] colisoes,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [3:0]             db_estado
);

  typedef logic [LARG_COORD:0] dist_t;
  localparam dist_t TOL = dist_t'(TOLERANCIA);

  estado_t                estado_reg, estado_next;
  logic                   perfurante_reg;
  logic [LARG_PONTOS-1:0] colisoes_reg;

  logic  limpa_tiro, conta_tiro, ultimo_tiro;
  logic  limpa_aste, conta_aste, ultimo_aste;
  dist_t dist_x, dist_y;
  logic  acerto;

  contador_m_rco #(.M(N_TIROS), .W(LT)) u_cont_tiro (
    .clock   (clock),
    .reset_n (reset_n),
    .limpa   (limpa_tiro),
    .conta   (conta_tiro),
    .valor   (tiro_addr),
    .rco     (ultimo_tiro)
  );

  contador_m_rco #(.M(N_ASTEROIDES), .W(LA)) u_cont_aste (
    .clock   (clock),
    .reset_n (reset_n),
    .limpa   (limpa_aste),
    .conta   (conta_aste),
    .valor   (aste_addr),
    .rco     (ultimo_aste)
  );

  // One extra bit keeps the difference unsigned; no screen wrap-around.
  always_comb begin
    dist_x = (tiro_x >= aste_x) ? ({1'b0, tiro_x} - {1'b0, aste_x})
                                : ({1'b0, aste_x} - {1'b0, tiro_x});
    dist_y = (tiro_y >= aste_y) ? ({1'b0, tiro_y} - {1'b0, aste_y})
                                : ({1'b0, aste_y} - {1'b0, tiro_y});
    acerto = tiro_ativo & aste_ativo & (dist_x <= TOL) & (dist_y <= TOL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg <= OCIOSO;
    end else begin
      estado_reg <= estado_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      OCIOSO:      estado_next = inicia ? INICIO : OCIOSO;
      INICIO:      estado_next = LE_TIRO;
      LE_TIRO:     estado_next = AVALIA_TIRO;
      AVALIA_TIRO: estado_next = tiro_ativo ? LE_ASTE : PROX_TIRO;
      LE_ASTE:     estado_next = COMPARA;
      COMPARA: begin
        if (acerto)           estado_next = APAGA;
        else if (ultimo_aste) estado_next = PROX_TIRO;
        else                  estado_next = LE_ASTE;
      end
      APAGA: begin
        if (perfurante_reg && !ultimo_aste) estado_next = LE_ASTE;
        else                                estado_next = PROX_TIRO;
      end
      PROX_TIRO:   estado_next = ultimo_tiro ? FIM : LE_TIRO;
      FIM:         estado_next = OCIOSO;
      default:     estado_next = OCIOSO;
    endcase
  end

  always_comb begin
    limpa_tiro = (estado_reg == INICIO);
    conta_tiro = (estado_reg == PROX_TIRO) && !ultimo_tiro;
    limpa_aste = (estado_reg == INICIO) || ((estado_reg == AVALIA_TIRO) && tiro_ativo);
    conta_aste = ((estado_reg == COMPARA) && !acerto && !ultimo_aste) ||
                 ((estado_reg == APAGA) && perfurante_reg && !ultimo_aste);
  end

  always_comb begin
    ocupado         = (estado_reg != OCIOSO);
    pronto          = (estado_reg == FIM);
    apaga_asteroide = (estado_reg == APAGA);
    apaga_tiro      = (estado_reg == APAGA) && !perfurante_reg;
    db_estado       = estado_reg;
    colisoes        = colisoes_reg;
  end

  // Mode is captured when the start request is accepted and held all sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perfurante_reg <= 1'b0;
    end else if (estado_reg == OCIOSO && inicia) begin
      perfurante_reg <= modo_perfurante;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      colisoes_reg <= '0;
    end else if (estado_reg == INICIO) begin
      colisoes_reg <= '0;
    end else if (estado_reg == APAGA && !(&colisoes_reg)) begin
      colisoes_reg <= colisoes_reg + 1'b1;
    end
  end

endmodule
